// File: rtl/cordic_iter_core.sv
// Iterative CORDIC core: one micro-rotation per clock on Q3.29 x/y/z.
// Define CORDIC_VECTORING_EN to add the vectoring-mode input port.
module cordic_iter_core #(
    parameter int WIDTH = 32,
    parameter int ITER  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef CORDIC_VECTORING_EN
    input  logic             mode,
`endif
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] y_in,
    input  logic [WIDTH-1:0] z_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] x_out,
    output logic [WIDTH-1:0] y_out,
    output logic [WIDTH-1:0] z_out
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [4:0] LAST = 5'(ITER - 1);

    state_t state, state_nx;
    logic [4:0] cnt, cnt_nx, idx;
    logic ld, step, fin, first, neg;
    logic signed [WIDTH-1:0] x_r, y_r, z_r;
    logic signed [WIDTH-1:0] x_a, y_a, z_a;
    logic signed [WIDTH-1:0] x_sh, y_sh, atan_i;
    logic signed [WIDTH-1:0] x_it, y_it, z_it;

    // round(atan(2^-i) * 2^29); from i=10 on this is exactly 2^(29-i)
    function automatic logic [31:0] atan_rom(input logic [4:0] i);
        logic [31:0] v;
        unique case (i)
            5'd0:    v = 32'h1921FB54;
            5'd1:    v = 32'h0ED63383;
            5'd2:    v = 32'h07D6DD7E;
            5'd3:    v = 32'h03FAB753;
            5'd4:    v = 32'h01FF55BB;
            5'd5:    v = 32'h00FFEAAE;
            5'd6:    v = 32'h007FFD55;
            5'd7:    v = 32'h003FFFAB;
            5'd8:    v = 32'h001FFFF5;
            5'd9:    v = 32'h000FFFFF;
            default: v = (i < 5'd30) ? (32'h1 << (5'd29 - i)) : 32'h0;
        endcase
        return v;
    endfunction

    // Back-to-back starts run iteration 0 straight off the inputs.
    assign first  = (state != RUN);
    assign idx    = first ? 5'd0 : cnt;
    assign x_a    = first ? x_in : x_r;
    assign y_a    = first ? y_in : y_r;
    assign z_a    = first ? z_in : z_r;
    assign x_sh   = x_a >>> idx;
    assign y_sh   = y_a >>> idx;
    assign atan_i = WIDTH'(atan_rom(idx));

`ifdef CORDIC_VECTORING_EN
    logic vec_r, vec_a;
    assign vec_a = first ? mode : vec_r;
    assign neg   = vec_a ? ~y_a[WIDTH-1] : z_a[WIDTH-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            vec_r <= 1'b0;
        else if (ld || (step && first))
            vec_r <= mode;
    end
`else
    assign neg = z_a[WIDTH-1];
`endif

    assign x_it = neg ? x_a + y_sh   : x_a - y_sh;
    assign y_it = neg ? y_a - x_sh   : y_a + x_sh;
    assign z_it = neg ? z_a + atan_i : z_a - atan_i;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        ld       = 1'b0;
        step     = 1'b0;
        fin      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    ld       = 1'b1;
                    cnt_nx   = 5'd0;
                    state_nx = RUN;
                end
            end
            RUN: begin
                step   = 1'b1;
                cnt_nx = cnt + 5'd1;
                if (cnt == LAST) begin
                    fin      = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
                if (start) begin
                    step   = 1'b1;
                    cnt_nx = 5'd1;
                    if (LAST == 5'd0) begin
                        fin      = 1'b1;
                        state_nx = DONE;
                    end else begin
                        state_nx = RUN;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
        busy = (state == RUN);
        done = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            x_r   <= '0;
            y_r   <= '0;
            z_r   <= '0;
            x_out <= '0;
            y_out <= '0;
            z_out <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (ld) begin
                x_r <= x_in;
                y_r <= y_in;
                z_r <= z_in;
            end else if (step) begin
                x_r <= x_it;
                y_r <= y_it;
                z_r <= z_it;
            end
            if (fin) begin
                x_out <= x_it;
                y_out <= y_it;
                z_out <= z_it;
            end
        end
    end

endmodule

// File: tb/tb_cordic_iter_core.sv
// Bench for cordic_iter_core: directed operations, reference model, per-cycle compare.
// Also drives an ITER=1 instance; vectoring is covered when CORDIC_VECTORING_EN is set.
module tb_cordic_iter_core;
    localparam int W = 32;
    localparam int N = 16;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic start  = 1'b0;
    logic start1 = 1'b0;
`ifdef CORDIC_VECTORING_EN
    logic mode   = 1'b0;
`endif
    logic [W-1:0] x_in = '0;
    logic [W-1:0] y_in = '0;
    logic [W-1:0] z_in = '0;
    logic busy, done, busy1, done1;
    logic [W-1:0] x_out, y_out, z_out, xo1, yo1, zo1;

    int errors = 0;
    int checks = 0;
    int atan_tab[32];

    always #5 clk = ~clk;

    cordic_iter_core #(.WIDTH(W), .ITER(N)) dut (
        .clk(clk), .rst(rst), .start(start),
`ifdef CORDIC_VECTORING_EN
        .mode(mode),
`endif
        .x_in(x_in), .y_in(y_in), .z_in(z_in),
        .busy(busy), .done(done),
        .x_out(x_out), .y_out(y_out), .z_out(z_out)
    );

    cordic_iter_core #(.WIDTH(W), .ITER(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1),
`ifdef CORDIC_VECTORING_EN
        .mode(mode),
`endif
        .x_in(x_in), .y_in(y_in), .z_in(z_in),
        .busy(busy1), .done(done1),
        .x_out(xo1), .y_out(yo1), .z_out(zo1)
    );

    // Reference: the micro-rotation recurrence written with d = +/-1.
    function automatic void cordic(input logic [31:0] xi, input logic [31:0] yi,
                                   input logic [31:0] zi, input bit vec, input int n,
                                   output logic [31:0] xo, output logic [31:0] yo,
                                   output logic [31:0] zo);
        int x, y, z, xn, yn, d;
        x = xi;
        y = yi;
        z = zi;
        for (int i = 0; i < n; i++) begin
            if (vec) d = (y < 0) ? 1 : -1;
            else     d = (z >= 0) ? 1 : -1;
            xn = x - d * (y >>> i);
            yn = y + d * (x >>> i);
            z  = z - d * atan_tab[i];
            x  = xn;
            y  = yn;
        end
        xo = x;
        yo = y;
        zo = z;
    endfunction

    // Timing model: which edge accepts, which edge finishes.
    int e = 0, acc_e = 0, fin_e = 0;
    bit have = 1'b0, m_busy = 1'b0, m_done = 1'b0, md = 1'b0;
    logic [31:0] m_x = '0, m_y = '0, m_z = '0;
    logic [31:0] p_x = '0, p_y = '0, p_z = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            have   = 1'b0;
            m_busy = 1'b0;
            m_done = 1'b0;
            m_x    = '0;
            m_y    = '0;
            m_z    = '0;
        end else begin
            e++;
            md = 1'b0;
`ifdef CORDIC_VECTORING_EN
            md = mode;
`endif
            if (start && !(have && e > acc_e && e <= fin_e)) begin
                fin_e = (have && e == fin_e + 1) ? e + N - 1 : e + N;
                acc_e = e;
                have  = 1'b1;
                cordic(x_in, y_in, z_in, md, N, p_x, p_y, p_z);
            end
            m_done = have && (e == fin_e);
            if (m_done) begin
                m_x = p_x;
                m_y = p_y;
                m_z = p_z;
            end
            m_busy = have && (e >= acc_e) && (e < fin_e);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_tol(input string nm, input logic [31:0] act,
                           input logic [31:0] exp, input int tol);
        int diff;
        diff = int'(act - exp);
        if (diff < 0) diff = -diff;
        checks++;
        if (diff > tol) begin
            errors++;
            $display("FAIL %s: got %h expected %h +/- %0d", nm, act, exp, tol);
        end
    endtask

    // lat = edges from the accepting edge to the edge that raised done
    task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] z, output int lat, output int nb);
        int t;
        @(negedge clk);
        x_in  = x;
        y_in  = y;
        z_in  = z;
        start = 1'b1;
        t  = 0;
        nb = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            t++;
            if (busy) nb++;
        end while (!done && t < 60);
        lat = t - 1;
    endtask

    initial begin
        logic [31:0] rx, ry, rz, bx, by, bz;
        int lat, nb, nd, cnt, t, t_prev;

        for (int i = 0; i < 32; i++)
            atan_tab[i] = $rtoi($atan(1.0 / (2.0 ** i)) * (2.0 ** 29) + 0.5);
        chk("rom0", atan_tab[0], 32'h1921FB54);
        chk("rom3", atan_tab[3], 32'h03FAB753);

        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_x", x_out, 32'd0);
        chk("rst_y", y_out, 32'd0);
        chk("rst_z", z_out, 32'd0);
        chk("rst_busy1", 32'(busy1), 32'd0);
        chk("rst_x1", xo1, 32'd0);
        rst = 1'b0;

        fork
            forever begin
                @(negedge clk);
                chk("cyc_busy", 32'(busy), 32'(m_busy));
                chk("cyc_done", 32'(done), 32'(m_done));
                chk("cyc_x", x_out, m_x);
                chk("cyc_y", y_out, m_y);
                chk("cyc_z", z_out, m_z);
            end
        join_none

        run_op(32'h136E9DB4, 32'h0, 32'h1921FB54, lat, nb);
        chk("lat_pi4", lat, N);
        chk_tol("pi4_x", x_out, 32'h16A09E66, 1 << 14);
        chk_tol("pi4_y", y_out, 32'h16A09E66, 1 << 14);
        chk_tol("pi4_z", z_out, 32'h0, 32'h4000);

        run_op(32'h136E9DB4, 32'h0, 32'h0, lat, nb);
        chk_tol("z0_x", x_out, 32'h20000000, 1 << 14);
        chk_tol("z0_y", y_out, 32'h0, 1 << 14);

        run_op(32'h136E9DB4, 32'h0, 32'hE6DE04AC, lat, nb);
        chk_tol("npi4_x", x_out, 32'h16A09E66, 1 << 14);
        chk_tol("npi4_y", y_out, 32'hE95F619A, 1 << 14);
        chk("npi4_busy", nb, N);

        // start re-pulsed during iteration 5 must be ignored
        cordic(32'h136E9DB4, 32'h0, 32'h1921FB54, 1'b0, N, rx, ry, rz);
        @(negedge clk);
        x_in = 32'h136E9DB4; y_in = 32'h0; z_in = 32'h1921FB54; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        x_in = 32'h20000000; y_in = 32'h10000000; z_in = 32'h08000000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nd = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("ign_ndone", nd, 1);
        chk("ign_x", x_out, rx);
        chk("ign_y", y_out, ry);
        chk("ign_z", z_out, rz);

        // asynchronous reset in the middle of iteration 8
        @(negedge clk);
        x_in = 32'h136E9DB4; y_in = 32'h0; z_in = 32'hE6DE04AC; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_x", x_out, 32'd0);
        chk("arst_y", y_out, 32'd0);
        chk("arst_z", z_out, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("arst_ndone", nd, 0);
        run_op(32'h136E9DB4, 32'h0, 32'h1921FB54, lat, nb);
        chk("arst_lat", lat, N);
        chk_tol("arst_x2", x_out, 32'h16A09E66, 1 << 14);

        // start held high: one done every N cycles, later ops sampled in DONE
        cordic(32'h136E9DB4, 32'h0, 32'h0, 1'b0, N, bx, by, bz);
        @(negedge clk);
        x_in = 32'h136E9DB4; y_in = 32'h0; z_in = 32'h1921FB54; start = 1'b1;
        @(negedge clk);
        z_in = 32'h0;
        t = 0; t_prev = 0; cnt = 0;
        repeat (60) begin
            @(negedge clk);
            t++;
            if (done) begin
                if (cnt > 0) chk("b2b_gap", t - t_prev, N);
                t_prev = t;
                cnt++;
            end
        end
        start = 1'b0;
        chk("b2b_count", cnt, 3);
        repeat (10) @(negedge clk);
        chk("b2b_x", x_out, bx);
        chk("b2b_y", y_out, by);
        chk("b2b_z", z_out, bz);

        // ITER=1 instance, including a DONE-cycle restart
        cordic(32'h136E9DB4, 32'h0, 32'h1921FB54, 1'b0, 1, rx, ry, rz);
        cordic(32'h20000000, 32'h0, 32'hE6DE04AC, 1'b0, 1, bx, by, bz);
        @(negedge clk);
        x_in = 32'h136E9DB4; y_in = 32'h0; z_in = 32'h1921FB54; start1 = 1'b1;
        @(negedge clk);
        chk("i1_busy", 32'(busy1), 32'd1);
        chk("i1_done0", 32'(done1), 32'd0);
        x_in = 32'h11111111;
        @(negedge clk);
        chk("i1_done", 32'(done1), 32'd1);
        chk("i1_x", xo1, rx);
        chk("i1_y", yo1, ry);
        chk("i1_z", zo1, rz);
        x_in = 32'h20000000; y_in = 32'h0; z_in = 32'hE6DE04AC;
        @(negedge clk);
        chk("i1b_done", 32'(done1), 32'd1);
        chk("i1b_x", xo1, bx);
        chk("i1b_y", yo1, by);
        chk("i1b_z", zo1, bz);
        start1 = 1'b0;
        @(negedge clk);
        chk("i1_idle_done", 32'(done1), 32'd0);
        chk("i1_idle_busy", 32'(busy1), 32'd0);

`ifdef CORDIC_VECTORING_EN
        mode = 1'b1;
        run_op(32'h20000000, 32'h20000000, 32'h0, lat, nb);
        mode = 1'b0;
        chk_tol("vec_y", y_out, 32'h0, 1 << 14);
        chk_tol("vec_z", z_out, 32'h1921FB54, 1 << 14);
        chk_tol("vec_x", x_out, $rtoi(1.6467602578 * 1.4142135624 * (2.0 ** 29)), 1 << 14);
`endif

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
